// File: rtl/fetch_queue_pkg.sv
// Shared pipeline types for the instruction-fetch front end.
package fetch_queue_pkg;

  localparam int FETCH_PC_W  = 9;
  localparam int FETCH_INS_W = 32;

  localparam logic [FETCH_INS_W-1:0] FETCH_BUBBLE = 32'h0;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order synchronous FIFO of fetched {pc, instr} entries with flush.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  // Storage needs no reset; entries are only visible once count covers them.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: credit-limited requests, in-order response queue, redirect flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int PC_W  = FETCH_PC_W,
  parameter int INS_W = FETCH_INS_W,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [PC_W-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [INS_W-1:0] imem_rsp_data,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             stall,
  output logic             if_valid,
  output logic [PC_W-1:0]  if_pc,
  output logic [INS_W-1:0] if_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] rsp_pc;
  logic [PC_W-1:0] redirect_base;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic            req_fire;
  logic            rsp_fire;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // A request is only offered when a queue slot is guaranteed for its response.
  assign imem_req_valid = reset && !redirect && ((inflight + count) < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && (inflight != '0);
  assign push           = rsp_fire && (drop_cnt == '0) && !redirect;
  assign pop            = if_valid && !stall && !redirect;
  assign redirect_base  = redirect_pc & ~PC_W'(3);
  assign push_entry     = '{pc: rsp_pc, instr: imem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .head       (head),
    .count      (count)
  );

  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? head.pc : '0;
  assign if_instr = if_valid ? head.instr : FETCH_BUBBLE;

  // Redirect marks every outstanding response stale, including one landing this cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= '0;
      rsp_pc   <= '0;
      inflight <= '0;
      drop_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_base;
      rsp_pc   <= redirect_base;
      inflight <= inflight - CW'(rsp_fire);
      drop_cnt <= inflight - CW'(rsp_fire);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + PC_W'(4);
      end
      if (push) begin
        rsp_pc <= rsp_pc + PC_W'(4);
      end
      inflight <= inflight + CW'(req_fire) - CW'(rsp_fire);
      if (rsp_fire && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order memory model plus a scoreboard of expected IF entries.
module tb_fetch_queue;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             imem_req_valid;
  logic             imem_req_ready = 1'b1;
  logic [PC_W-1:0]  imem_req_addr;
  logic             imem_rsp_valid = 1'b0;
  logic [INS_W-1:0] imem_rsp_data = '0;
  logic             redirect = 1'b0;
  logic [PC_W-1:0]  redirect_pc = '0;
  logic             stall = 1'b0;
  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic [INS_W-1:0] if_instr;

  fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [PC_W-1:0]  addr;
    logic [INS_W-1:0] data;
    int               due;
    bit               stale;
    bit               orphan;
  } mem_txn_t;

  typedef struct {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } sb_entry_t;

  mem_txn_t  pending[$];
  sb_entry_t exp_q[$];
  logic [PC_W-1:0] exp_fetch_pc = '0;
  int cyc = 0;
  int lat = 1;
  int n_checks = 0;
  int n_fail = 0;

  int               inflight_m;
  bit               exp_rv, exp_iv, f_req, f_pop, f_rsp, keep;
  logic [PC_W-1:0]  exp_pc, exp_addr;
  logic [INS_W-1:0] exp_in;
  mem_txn_t         t;

  // Memory model and scoreboard: compare on the falling edge, advance on the rising edge.
  initial begin
    forever begin
      @(negedge clock);
      inflight_m = 0;
      foreach (pending[i]) if (!pending[i].orphan) inflight_m++;
      exp_rv   = reset && !redirect && ((inflight_m + exp_q.size()) < DEPTH);
      exp_iv   = reset && (exp_q.size() != 0);
      exp_pc   = exp_iv ? exp_q[0].pc : '0;
      exp_in   = exp_iv ? exp_q[0].instr : '0;
      exp_addr = reset ? exp_fetch_pc : '0;
      n_checks++;
      if (imem_req_valid !== exp_rv) begin
        n_fail++; $display("[TB] FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
      end
      n_checks++;
      if (imem_req_addr !== exp_addr) begin
        n_fail++; $display("[TB] FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_addr);
      end
      n_checks++;
      if (if_valid !== exp_iv) begin
        n_fail++; $display("[TB] FAIL if_valid cyc=%0d got=%b exp=%b", cyc, if_valid, exp_iv);
      end
      n_checks++;
      if (if_pc !== exp_pc) begin
        n_fail++; $display("[TB] FAIL if_pc cyc=%0d got=%h exp=%h", cyc, if_pc, exp_pc);
      end
      n_checks++;
      if (if_instr !== exp_in) begin
        n_fail++; $display("[TB] FAIL if_instr cyc=%0d got=%h exp=%h", cyc, if_instr, exp_in);
      end
      f_req = exp_rv && imem_req_ready;
      f_pop = exp_iv && !stall && !redirect;
      f_rsp = imem_rsp_valid;

      @(posedge clock);
      if (!reset) begin
        if (f_rsp && pending.size() > 0) void'(pending.pop_front());
        exp_q.delete();
        foreach (pending[i]) pending[i].orphan = 1'b1;
        exp_fetch_pc = '0;
      end else begin
        keep = 1'b0;
        if (f_rsp && pending.size() > 0) begin
          t = pending.pop_front();
          keep = !t.orphan && !t.stale && !redirect;
        end
        if (f_pop) void'(exp_q.pop_front());
        if (keep) exp_q.push_back('{pc: t.addr, instr: t.data});
        if (redirect) begin
          exp_q.delete();
          foreach (pending[i]) pending[i].stale = 1'b1;
          exp_fetch_pc = redirect_pc & ~PC_W'(3);
        end else if (f_req) begin
          pending.push_back('{addr: exp_fetch_pc, data: $urandom, due: cyc + lat, stale: 1'b0, orphan: 1'b0});
          exp_fetch_pc = exp_fetch_pc + PC_W'(4);
        end
      end
      cyc++;

      #1;
      if (pending.size() > 0 && pending[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pending[0].data;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #3;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    n_checks++; if (imem_req_addr !== '0) begin n_fail++; $display("[TB] FAIL reset_req_addr got=%h exp=0", imem_req_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_if_valid got=%b exp=0", if_valid); end
    n_checks++; if (if_pc !== '0) begin n_fail++; $display("[TB] FAIL reset_if_pc got=%h exp=0", if_pc); end
    n_checks++; if (if_instr !== '0) begin n_fail++; $display("[TB] FAIL reset_if_instr got=%h exp=0", if_instr); end
    @(posedge clock); #1;
    reset = 1'b1;
    #2;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== '0) begin
      n_fail++; $display("[TB] FAIL first_req got=%b/%h exp=1/000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_c1_valid got=%b exp=0", if_valid); end
    @(posedge clock); #3;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_c2_valid got=%b exp=0", if_valid); end
    @(posedge clock); #3;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 9'h000) begin
      n_fail++; $display("[TB] FAIL stream_c3_head got=%b/%h exp=1/000", if_valid, if_pc);
    end
    @(posedge clock); #3;
    n_checks++; if (if_pc !== 9'h004) begin n_fail++; $display("[TB] FAIL stream_c4_pc got=%h exp=004", if_pc); end
    repeat (6) @(posedge clock);
  endtask

  task automatic test_stall();
    @(posedge clock); #1;
    stall = 1'b1;
    repeat (5) @(posedge clock);
    #3;
    n_checks++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL stall_cap got=%b/%b exp=0/1", imem_req_valid, if_valid);
    end
    @(posedge clock); #1;
    stall = 1'b0;
    repeat (8) @(posedge clock);
  endtask

  task automatic test_redirect_drop();
    bit found = 1'b0;
    @(posedge clock); #1;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 20 && (pending.size() != 0 || exp_q.size() != 0); i++) @(posedge clock);
    @(posedge clock); #1;
    lat = 3;
    imem_req_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    redirect = 1'b1;
    redirect_pc = 9'h040;
    #2;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_req_valid got=%b exp=0", imem_req_valid); end
    @(posedge clock); #1;
    redirect = 1'b0;
    #2;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 9'h040) begin
      n_fail++; $display("[TB] FAIL redir_new_req got=%b/%h exp=1/040", imem_req_valid, imem_req_addr);
    end
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge clock); #3;
      if (if_valid) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("[TB] FAIL redir_head_timeout got=no_if_valid exp=if_valid within 12 cycles");
    end else if (if_pc !== 9'h040) begin
      n_fail++; $display("[TB] FAIL redir_head_pc got=%h exp=040", if_pc);
    end
    repeat (6) @(posedge clock);
  endtask

  task automatic test_collision();
    @(posedge clock); #1;
    lat = 1;
    repeat (10) @(posedge clock);
    #1;
    redirect = 1'b1;
    redirect_pc = 9'h100;
    #2;
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL coll_pre_valid got=%b exp=1", if_valid); end
    @(posedge clock); #1;
    redirect = 1'b0;
    #2;
    n_checks++; if (if_valid !== 1'b0 || if_instr !== '0 || if_pc !== '0) begin
      n_fail++; $display("[TB] FAIL coll_flushed got=%b/%h/%h exp=0/000/00000000", if_valid, if_pc, if_instr);
    end
    repeat (6) @(posedge clock);
  endtask

  task automatic test_wrap();
    @(posedge clock); #1;
    redirect = 1'b1;
    redirect_pc = 9'h1F8;
    @(posedge clock); #1;
    redirect = 1'b0;
    #2;
    n_checks++; if (imem_req_addr !== 9'h1F8) begin n_fail++; $display("[TB] FAIL wrap_1f8 got=%h exp=1f8", imem_req_addr); end
    @(posedge clock); #3;
    n_checks++; if (imem_req_addr !== 9'h1FC) begin n_fail++; $display("[TB] FAIL wrap_1fc got=%h exp=1fc", imem_req_addr); end
    @(posedge clock); #3;
    n_checks++; if (imem_req_addr !== 9'h000) begin n_fail++; $display("[TB] FAIL wrap_000 got=%h exp=000", imem_req_addr); end
    repeat (4) @(posedge clock);
    #1;
    redirect = 1'b1;
    redirect_pc = 9'h0A7;
    @(posedge clock); #1;
    redirect = 1'b0;
    #2;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 9'h0A4) begin
      n_fail++; $display("[TB] FAIL align_0a4 got=%b/%h exp=1/0a4", imem_req_valid, imem_req_addr);
    end
    repeat (6) @(posedge clock);
  endtask

  task automatic test_async_reset();
    @(posedge clock); #1;
    lat = 3;
    repeat (8) @(posedge clock);
    #2;
    reset = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    n_checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== '0) begin
      n_fail++; $display("[TB] FAIL areset_req got=%b/%h exp=0/000", imem_req_valid, imem_req_addr);
    end
    n_checks++; if (if_valid !== 1'b0 || if_pc !== '0 || if_instr !== '0) begin
      n_fail++; $display("[TB] FAIL areset_if got=%b/%h/%h exp=0/000/00000000", if_valid, if_pc, if_instr);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 8 && pending.size() != 0; i++) @(posedge clock);
    @(posedge clock); #3;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_late_rsp got=%b exp=0", if_valid); end
    @(posedge clock); #1;
    imem_req_ready = 1'b1;
    #2;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== '0) begin
      n_fail++; $display("[TB] FAIL areset_restart got=%b/%h exp=1/000", imem_req_valid, imem_req_addr);
    end
    repeat (10) @(posedge clock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_collision();
    test_wrap();
    test_async_reset();
    @(posedge clock); #1;
    imem_req_ready = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
